// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared state encoding and default width for the
// up-counter sequencing controller.
package counter_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/counter_ctrl_cnt_core.sv
// cnt_core: WIDTH-bit up-counter register. Clear wins over enable; the
// increment wraps modulo 2^WIDTH.
module cnt_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    // Counter register: async reset, synchronous clear, then enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller for the up-counter datapath.
// Accepts a start with a terminal value, counts 0..limit with pause/abort,
// then raises a terminal-count strobe and a one-cycle done pulse.
// Optional feature: define COUNTER_CTRL_AUTO_RELOAD_EN for periodic mode,
// where the terminal count clears the counter and the run continues.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] lim_reg;
    logic             lim_load;
    logic             cnt_clr;
    logic             cnt_en;
    logic             tc_next;
    logic             at_limit;

    // The counter register itself; this block only decides clear/enable.
    cnt_core #(
        .WIDTH (WIDTH)
    ) u_cnt_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .q     (cnt)
    );

    assign at_limit = (cnt == lim_reg);

    // State and latched terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            lim_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (lim_load) begin
                lim_reg <= limit;
            end
        end
    end

    // Next-state, counter control and terminal-count decode.
    always_comb begin
        state_next = state_reg;
        lim_load   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        tc_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    lim_load = 1'b1;
                    cnt_clr  = 1'b1;
                    // A zero terminal value has nothing to count: finish at once.
                    state_next = (limit != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                end else if (pause) begin
                    state_next = HOLD;
                end else if (at_limit) begin
                    tc_next = 1'b1;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
                    // Periodic mode: restart from zero without leaving RUN.
                    cnt_clr = 1'b1;
`else
                    state_next = DONE;
`endif
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                end else if (!pause) begin
                    // Resume edge only returns to RUN; counting restarts next cycle.
                    state_next = RUN;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == RUN) || (state_reg == HOLD);
    assign done = (state_reg == DONE);
    assign tc   = tc_next;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: self-checking bench for counter_ctrl with directed
// scenarios and a randomized run against a cycle-level behavioural model.
module tb_counter_ctrl;

    localparam int W = 4;

    // Model phases, named after what the controller is doing.
    localparam int M_IDLE     = 0;
    localparam int M_COUNTING = 1;
    localparam int M_PAUSED   = 2;
    localparam int M_FINISHED = 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] limit;
    logic         pause;
    logic         abort;
    logic [W-1:0] cnt;
    logic         busy;
    logic         tc;
    logic         done;

    int total = 0;
    int bad   = 0;

    int   m_mode;
    int   m_cnt;
    int   m_lim;
    logic tc_obs;
    logic tc_exp;

    counter_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .limit (limit),
        .pause (pause),
        .abort (abort),
        .cnt   (cnt),
        .busy  (busy),
        .tc    (tc),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic m_busy();
        return (m_mode == M_COUNTING) || (m_mode == M_PAUSED);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cnt  = 0;
        m_lim  = 0;
    endtask

    // Drive one cycle of inputs, sample tc before the edge, advance the model.
    // Called at posedge+1; returns at the following posedge+1.
    task automatic tick(input logic s, input logic [W-1:0] l, input logic p, input logic a);
        start = s;
        limit = l;
        pause = p;
        abort = a;
        #1;
        tc_obs = tc;
        tc_exp = (m_mode == M_COUNTING) && (m_cnt == m_lim) && !p && !a;
        case (m_mode)
            M_IDLE: begin
                if (s) begin
                    $display("txn start limit=%0d t=%0t", l, $time);
                    m_lim  = int'(l);
                    m_cnt  = 0;
                    m_mode = (l == 0) ? M_FINISHED : M_COUNTING;
                end
            end
            M_COUNTING: begin
                if (a) begin
                    m_mode = M_IDLE;
                    m_cnt  = 0;
                end else if (p) begin
                    m_mode = M_PAUSED;
                end else if (m_cnt == m_lim) begin
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
                    m_cnt = 0;
`else
                    m_mode = M_FINISHED;
`endif
                end else begin
                    m_cnt = (m_cnt + 1) % (1 << W);
                end
            end
            M_PAUSED: begin
                if (a) begin
                    m_mode = M_IDLE;
                    m_cnt  = 0;
                end else if (!p) begin
                    m_mode = M_COUNTING;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        $display("txn reset check t=%0t", $time);
        #1;
        total++; if (cnt !== '0)  begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
        total++; if (busy !== 0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 0)  begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (tc !== 0)    begin bad++; $display("FAIL reset_tc got=%b want=0", tc); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        total++; if (busy !== 0)  begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_midrun();
        tick(1, 4'd5, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        total++; if (cnt !== 4'd2) begin bad++; $display("FAIL rstmid_pre_cnt got=%0d want=2", cnt); end
        #2;
        rst_n = 1'b0;
        $display("txn async reset mid-run t=%0t", $time);
        #1;
        total++; if (cnt !== '0)  begin bad++; $display("FAIL rstmid_cnt got=%0d want=0", cnt); end
        total++; if (busy !== 0)  begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (done !== 0)  begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
        total++; if (tc !== 0)    begin bad++; $display("FAIL rstmid_tc got=%b want=0", tc); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick(0, 0, 0, 0);
        total++; if (busy !== 0 || done !== 0 || cnt !== '0) begin
            bad++; $display("FAIL rstmid_after busy=%b done=%b cnt=%0d want 0/0/0", busy, done, cnt);
        end
    endtask

    task automatic test_limit_zero();
        tick(1, 4'd0, 0, 0);
        total++; if (tc_obs !== 0) begin bad++; $display("FAIL zero_tc got=%b want=0", tc_obs); end
        total++; if (done !== 1)   begin bad++; $display("FAIL zero_done got=%b want=1", done); end
        total++; if (cnt !== '0)   begin bad++; $display("FAIL zero_cnt got=%0d want=0", cnt); end
        total++; if (busy !== 0)   begin bad++; $display("FAIL zero_busy got=%b want=0", busy); end
        tick(0, 0, 0, 0);
        total++; if (tc_obs !== 0) begin bad++; $display("FAIL zero_tc2 got=%b want=0", tc_obs); end
        total++; if (done !== 0)   begin bad++; $display("FAIL zero_done2 got=%b want=0", done); end
    endtask

`ifndef COUNTER_CTRL_AUTO_RELOAD_EN
    task automatic test_oneshot();
        tick(1, 4'd3, 0, 0);
        total++; if (cnt !== 4'd0 || busy !== 1) begin
            bad++; $display("FAIL oneshot_start cnt=%0d busy=%b want 0/1", cnt, busy);
        end
        for (int k = 1; k <= 3; k++) begin
            tick(0, 0, 0, 0);
            total++; if (cnt !== W'(k)) begin bad++; $display("FAIL oneshot_cnt got=%0d want=%0d", cnt, k); end
            total++; if (tc_obs !== 0)  begin bad++; $display("FAIL oneshot_tc_early got=%b want=0 k=%0d", tc_obs, k); end
        end
        tick(0, 0, 0, 0);
        total++; if (tc_obs !== 1) begin bad++; $display("FAIL oneshot_tc got=%b want=1", tc_obs); end
        total++; if (done !== 1)   begin bad++; $display("FAIL oneshot_done got=%b want=1", done); end
        total++; if (cnt !== 4'd3) begin bad++; $display("FAIL oneshot_done_cnt got=%0d want=3", cnt); end
        tick(0, 0, 0, 0);
        total++; if (done !== 0 || busy !== 0 || cnt !== 4'd3) begin
            bad++; $display("FAIL oneshot_idle done=%b busy=%b cnt=%0d want 0/0/3", done, busy, cnt);
        end
        total++; if (tc_obs !== 0) begin bad++; $display("FAIL oneshot_tc_after got=%b want=0", tc_obs); end
    endtask

    task automatic test_pause();
        int n;
        logic p;
        tick(1, 4'd4, 0, 0);
        n = 0;
        while (done !== 1 && n < 30) begin
            n++;
            p = (n >= 3 && n <= 5);
            tick(0, 0, p, 0);
            if (n >= 3 && n <= 6) begin
                total++; if (cnt !== 4'd2) begin bad++; $display("FAIL pause_frozen got=%0d want=2 n=%0d", cnt, n); end
            end
            total++; if (busy !== m_busy() || done !== (m_mode == M_FINISHED) || cnt !== W'(m_cnt)) begin
                bad++; $display("FAIL pause_model busy=%b done=%b cnt=%0d want %b/%b/%0d n=%0d",
                                busy, done, cnt, m_busy(), (m_mode == M_FINISHED), m_cnt, n);
            end
        end
        total++; if (done !== 1) begin bad++; $display("FAIL pause_done_timeout got=%b want=1", done); end
        total++; if (n <= 5)     begin bad++; $display("FAIL pause_delay ticks=%0d want>5", n); end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_abort();
        int n;
        logic seen;
        seen = 0;
        tick(1, 4'd9, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            tick(0, 0, 0, 0);
            seen = seen | tc_obs | done;
        end
        total++; if (cnt !== 4'd5) begin bad++; $display("FAIL abort_pre_cnt got=%0d want=5", cnt); end
        tick(0, 0, 0, 1);
        seen = seen | tc_obs | done;
        total++; if (cnt !== '0 || busy !== 0) begin
            bad++; $display("FAIL abort_effect cnt=%0d busy=%b want 0/0", cnt, busy);
        end
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 0);
            seen = seen | tc_obs | done;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_tc_done got=%b want=0", seen); end
        tick(1, 4'd2, 0, 0);
        n = 0;
        while (done !== 1 && n < 10) begin
            n++;
            tick(0, 0, 0, 0);
        end
        total++; if (n !== 3)      begin bad++; $display("FAIL abort_restart_latency got=%0d want=3", n); end
        total++; if (cnt !== 4'd2) begin bad++; $display("FAIL abort_restart_cnt got=%0d want=2", cnt); end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_start_busy();
        int n;
        tick(1, 4'd3, 0, 0);
        tick(1, 4'd9, 0, 0);
        total++; if (cnt !== 4'd1) begin bad++; $display("FAIL busystart_cnt got=%0d want=1", cnt); end
        n = 1;
        while (done !== 1 && n < 20) begin
            n++;
            tick(1, 4'd9, 0, 0);
        end
        total++; if (n !== 4)      begin bad++; $display("FAIL busystart_latency got=%0d want=4", n); end
        total++; if (cnt !== 4'd3) begin bad++; $display("FAIL busystart_final got=%0d want=3", cnt); end
        tick(0, 0, 0, 0);
    endtask

    task automatic test_limit_max();
        logic wrapped;
        wrapped = 0;
        tick(1, 4'd15, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            tick(0, 0, 0, 0);
            if (cnt !== W'(k)) wrapped = 1;
        end
        total++; if (wrapped !== 0) begin bad++; $display("FAIL max_sequence got=bad want=0..15 last=%0d", cnt); end
        tick(0, 0, 0, 0);
        total++; if (tc_obs !== 1)  begin bad++; $display("FAIL max_tc got=%b want=1", tc_obs); end
        total++; if (done !== 1 || cnt !== 4'd15) begin
            bad++; $display("FAIL max_done done=%b cnt=%0d want 1/15", done, cnt);
        end
        tick(0, 0, 0, 0);
    endtask
`else
    task automatic test_reload();
        tick(1, 4'd2, 0, 0);
        total++; if (cnt !== 4'd0) begin bad++; $display("FAIL reload_start got=%0d want=0", cnt); end
        for (int k = 1; k <= 9; k++) begin
            tick(0, 0, 0, 0);
            total++; if (cnt !== W'(k % 3)) begin bad++; $display("FAIL reload_cnt got=%0d want=%0d", cnt, k % 3); end
            total++; if (tc_obs !== ((k % 3) == 0)) begin
                bad++; $display("FAIL reload_tc got=%b want=%b k=%0d", tc_obs, ((k % 3) == 0), k);
            end
            total++; if (done !== 0 || busy !== 1) begin
                bad++; $display("FAIL reload_flags done=%b busy=%b want 0/1", done, busy);
            end
        end
        tick(0, 0, 0, 1);
        total++; if (busy !== 0 || cnt !== '0 || done !== 0) begin
            bad++; $display("FAIL reload_abort busy=%b cnt=%0d done=%b want 0/0/0", busy, cnt, done);
        end
    endtask
`endif

    task automatic test_random();
        logic         s;
        logic [W-1:0] l;
        logic         p;
        logic         a;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 4));
            p = ($urandom_range(0, 5) == 0);
            a = ($urandom_range(0, 24) == 0);
            tick(s, l, p, a);
            total++; if (tc_obs !== tc_exp) begin bad++; $display("FAIL rand_tc got=%b want=%b i=%0d", tc_obs, tc_exp, i); end
            total++; if (cnt !== W'(m_cnt)) begin bad++; $display("FAIL rand_cnt got=%0d want=%0d i=%0d", cnt, m_cnt, i); end
            total++; if (busy !== m_busy()) begin bad++; $display("FAIL rand_busy got=%b want=%b i=%0d", busy, m_busy(), i); end
            total++; if (done !== (m_mode == M_FINISHED)) begin
                bad++; $display("FAIL rand_done got=%b want=%b i=%0d", done, (m_mode == M_FINISHED), i);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        limit = '0;
        pause = 1'b0;
        abort = 1'b0;
        model_reset();
        test_reset();
        test_reset_midrun();
        test_limit_zero();
`ifndef COUNTER_CTRL_AUTO_RELOAD_EN
        test_oneshot();
        test_pause();
        test_abort();
        test_start_busy();
        test_limit_max();
`else
        test_reload();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
